bit_serial_adder: RTL and testbench
===================================

Name: bit_serial_adder

Overview:
Parametrised successor to the team's 1-bit full adder. It adds two WIDTH-bit operands plus a carry-in using a single full-adder slice, processing one bit per clock, LSB first. Operands arrive on a valid/ready input handshake, and results leave on a valid/ready output handshake. It is area-lean arithmetic for the TinyTapeout top wrapper, where one slice is time-multiplexed instead of instantiating WIDTH slices.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands a, b and cin are valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  operand A (unsigned or two's complement).
b  input  WIDTH  operand B.
cin  input  1  carry-in.
out_valid  output  1  sum, cout and ovf are valid.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
cout  output  1  carry out of the MSB.
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
busy  output  1  high in RUN or DONE.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state is updated on the rising edge of clk only.
- Reset values: state=IDLE, sum=0, cout=0, ovf=0, out_valid=0, busy=0, internal carry=0, bit counter=0.
- in_ready is combinational and equals (state==IDLE && !rst).
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - When in_valid && in_ready, latch a and b into shift registers A_sh and B_sh, load carry with cin, clear the counter, and go to RUN.
  - With no handshake, stay in IDLE.
- RUN, one bit per cycle:
  - The slice computes s = A_sh[0]^B_sh[0]^carry and c = majority(A_sh[0], B_sh[0], carry).
  - s shifts into the MSB of sum_sh (shift right). A_sh and B_sh shift right. carry<=c and count<=count+1.
  - On the cycle that processes bit WIDTH-1, capture ovf = carry_in_to_msb ^ c, capture cout = c, and go to DONE.
- Latency: if the input handshake occurs at edge k, out_valid is high after edge k+WIDTH. For WIDTH=1, RUN lasts exactly one cycle.
- DONE:
  - out_valid=1. sum, cout and ovf stay stable while out_valid && !out_ready.
  - When out_valid && out_ready, go to IDLE and drop out_valid at that edge.
- Back-pressure:
  - In DONE, in_ready=0, so a new operand cannot be accepted in the same cycle the result is consumed.
  - Peak throughput is one add per WIDTH+2 cycles.
- a, b, cin and in_valid are ignored outside IDLE, and changing them during RUN has no effect.
- Reset mid-operation, in any state: the result is abandoned, all outputs return to reset values at the next edge, and in_ready=1 after rst falls.
- sum is driven from sum_sh and shows partial shift contents during RUN. Consumers sample sum only when out_valid=1.
- Wrap-around: sum is always modulo 2^WIDTH, and the carry is reported only via cout.
- Counter width is $clog2(WIDTH+1). There is no overflow of the counter, because it clears on every accept.

Optional Feature:
Macro BSA_SUBTRACT_EN.
- When defined:
  - Adds input port sub (1 bit), sampled at the IDLE handshake.
  - When sub=1, B is latched inverted and the initial carry is forced to 1, so the result is a - b and cin is ignored.
  - cout=1 means no borrow. ovf is the signed subtraction overflow.
- When undefined:
  - The sub port does not exist, and the block always adds.
  - Gate count is identical to the add-only build apart from removal of the inverter/mux.

Decomposition:
- Package bsa_pkg contains:
  - the state enum typedef (IDLE, RUN, DONE, 2-bit);
  - localparam function cnt_w(width) returning $clog2(width+1);
  - the WIDTH_MIN=1 and WIDTH_MAX=32 constants used by an elaboration-time range check.
- Sub-module full_adder_slice: pure combinational 1-bit full adder (a, b, ci -> s, co), instantiated once. It is the reusable leaf for future ripple variants.

Test Plan:
- WIDTH=8, a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; out_valid rises exactly 8 cycles after the accept edge.
- WIDTH=8, 0xFF+0x01 cin=0 -> sum=0x00, cout=1, ovf=0; 0xFF+0xFF cin=1 -> sum=0xFF, cout=1, ovf=0.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands -> sum, cout and ovf stay stable, in_ready=0, and no new operand is taken. out_ready=1 -> IDLE next edge, and the next operand is accepted one cycle later.
- Reset mid-RUN after 3 bits -> at the next edge out_valid=0, sum=0, busy=0, and in_ready=1 once rst=0. A following 0x03+0x04 gives 0x07 with correct latency.
- WIDTH=1, all 8 combinations of a, b, cin -> sum and cout match a full-adder truth table, with out_valid one cycle after accept.
- With BSA_SUBTRACT_EN, WIDTH=8:
  - 0x05-0x07 -> sum=0xFE, cout=0, ovf=0.
  - 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
  - sub=0 reproduces add results.

Source files
------------

// File: rtl/bsa_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the FSM state encoding, the legal WIDTH range and the counter-width helper.
package bsa_pkg;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // The counter must be able to hold WIDTH itself, not just WIDTH-1.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_adder_slice.sv
// Pure combinational 1-bit full adder.
// This is the single arithmetic leaf that bit_serial_adder time-multiplexes.
module full_adder_slice (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice, one bit per clock, LSB first,
// with valid/ready on both sides. Define BSA_SUBTRACT_EN to add the 'sub' port (a - b).
module bit_serial_adder
    import bsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef BSA_SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int               CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
            $error("bit_serial_adder: WIDTH out of range");
        end
    endgenerate

    state_e             state;
    state_e             state_next;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_sh;
    logic [WIDTH-1:0]   sum_next;
    logic [WIDTH-1:0]   b_load;
    logic               carry;
    logic               carry_load;
    logic [CNT_W-1:0]   cnt;
    logic               cout_q;
    logic               ovf_q;
    logic               slice_s;
    logic               slice_co;
    logic               accept;
    logic               last_bit;

    // Subtraction is a + ~b + 1: invert B on load and force the initial carry.
`ifdef BSA_SUBTRACT_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub | cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    assign accept   = in_valid && in_ready;
    assign last_bit = (cnt == LAST_BIT);

    full_adder_slice u_slice (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
    );

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        sum_next            = sum_sh >> 1;
        sum_next[WIDTH-1]   = slice_s;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
        busy      = (state == RUN) || (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh  <= a;
                        b_sh  <= b_load;
                        carry <= carry_load;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_next;
                    carry  <= slice_co;
                    cnt    <= cnt + CNT_W'(1);
                    // On the MSB, 'carry' is the carry into the MSB.
                    if (last_bit) begin
                        cout_q <= slice_co;
                        ovf_q  <= carry ^ slice_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_sh;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed self-checking bench for bit_serial_adder (WIDTH=8 and WIDTH=1 instances).
// Subtraction vectors are included when BSA_SUBTRACT_EN is defined.
module tb_bit_serial_adder;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8, ovf8, busy8;
    logic [7:0] a8, b8, sum8;

    logic       in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, ovf1, busy1;
    logic [0:0] a1, b1, sum1;

`ifdef BSA_SUBTRACT_EN
    logic       sub8;
    logic       sub1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
`ifdef BSA_SUBTRACT_EN
        .sub       (sub8),
`endif
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
        .cout      (cout8),
        .ovf       (ovf8),
        .busy      (busy8)
    );

    bit_serial_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
`ifdef BSA_SUBTRACT_EN
        .sub       (sub1),
`endif
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1),
        .ovf       (ovf1),
        .busy      (busy1)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Wait (bounded) for out_valid, check latency and result, then consume it.
    task automatic wait_result8(input string tag, input logic [7:0] exp_sum,
                                input logic exp_cout, input logic exp_ovf);
        int n = 0;
        while (!out_valid8 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, n, 8);
        check({tag, "_sum"}, {24'd0, sum8}, {24'd0, exp_sum});
        check({tag, "_cout"}, {31'd0, cout8}, {31'd0, exp_cout});
        check({tag, "_ovf"}, {31'd0, ovf8}, {31'd0, exp_ovf});
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        check({tag, "_drop_valid"}, {31'd0, out_valid8}, 32'd0);
    endtask

    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
        a8 = a;
        b8 = b;
        cin8 = cin;
`ifdef BSA_SUBTRACT_EN
        sub8 = sub;
`else
        if (sub) $error("FAIL start8: subtract requested without BSA_SUBTRACT_EN");
`endif
        in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic add8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, input logic [7:0] exp_sum, input logic exp_cout,
                        input logic exp_ovf);
        start8(a, b, cin, sub);
        wait_result8(tag, exp_sum, exp_cout, exp_ovf);
    endtask

    initial begin
        logic [7:0] fa_sum_tbl;
        logic [7:0] fa_cout_tbl;
        logic [2:0] idx;
        int         n;

        rst = 1'b1;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
`ifdef BSA_SUBTRACT_EN
        sub8 = 1'b0;
        sub1 = 1'b0;
`endif

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid8}, 32'd0);
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_sum", {24'd0, sum8}, 32'd0);
        check("rst_cout", {31'd0, cout8}, 32'd0);
        check("rst_ovf", {31'd0, ovf8}, 32'd0);
        check("rst_in_ready_held", {31'd0, in_ready8}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready_released", {31'd0, in_ready8}, 32'd1);

        // Basic additions.
        add8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        add8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        add8("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
        add8("add_3c_5a_c", 8'h3C, 8'h5A, 1'b1, 1'b0, 8'h97, 1'b0, 1'b1);
        add8("add_80_80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Back-pressure: hold the result while new operands are offered.
        start8(8'h12, 8'h34, 1'b0, 1'b0);
        n = 0;
        while (!out_valid8 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_latency", n, 8);
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; in_valid8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_sum", {24'd0, sum8}, 32'h46);
            check("bp_hold_cout", {31'd0, cout8}, 32'd0);
            check("bp_hold_ovf", {31'd0, ovf8}, 32'd0);
            check("bp_hold_valid", {31'd0, out_valid8}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready8}, 32'd0);
        end
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        check("bp_release_valid", {31'd0, out_valid8}, 32'd0);
        check("bp_release_in_ready", {31'd0, in_ready8}, 32'd1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        check("bp_next_accepted_busy", {31'd0, busy8}, 32'd1);
        check("bp_next_accepted_ready", {31'd0, in_ready8}, 32'd0);
        wait_result8("bp_next", 8'hFF, 1'b0, 1'b0);

        // Reset after three bits of RUN.
        start8(8'hF0, 8'h0F, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_out_valid", {31'd0, out_valid8}, 32'd0);
        check("midrst_sum", {24'd0, sum8}, 32'd0);
        check("midrst_busy", {31'd0, busy8}, 32'd0);
        check("midrst_cout", {31'd0, cout8}, 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, in_ready8}, 32'd1);
        add8("after_rst_03_04", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);

        // WIDTH=1: full-adder truth table, index = {a, b, cin}.
        fa_sum_tbl  = 8'b1001_0110;
        fa_cout_tbl = 8'b1110_1000;
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            a1 = idx[2];
            b1 = idx[1];
            cin1 = idx[0];
            in_valid1 = 1'b1;
            @(posedge clk); #1;
            in_valid1 = 1'b0;
            n = 0;
            while (!out_valid1 && n < 5) begin
                @(posedge clk); #1;
                n++;
            end
            check("w1_latency", n, 1);
            check($sformatf("w1_sum_%0d", i), {31'd0, sum1}, {31'd0, fa_sum_tbl[idx]});
            check($sformatf("w1_cout_%0d", i), {31'd0, cout1}, {31'd0, fa_cout_tbl[idx]});
            check($sformatf("w1_ovf_%0d", i), {31'd0, ovf1}, {31'd0, idx[0] ^ fa_cout_tbl[idx]});
            out_ready1 = 1'b1;
            @(posedge clk); #1;
            out_ready1 = 1'b0;
            check("w1_drop_valid", {31'd0, out_valid1}, 32'd0);
        end

`ifdef BSA_SUBTRACT_EN
        add8("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        add8("sub_05_07_cin_ignored", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        add8("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        add8("sub0_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
